// File: rtl/uart_rx_packet.sv
// Framed-packet receiver: sync/length/XOR-checksum framing into a commit-gated byte FIFO.
// Optional inter-byte timeout is compiled in with `define UART_PKT_TIMEOUT_EN.
module uart_rx_packet #(
  parameter int         MAX_LEN        = 16,
  parameter int         DEPTH          = 32,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_SYNC, S_LEN, S_PAYLOAD, S_CHECK} state_t;

  state_t      state;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  logic [AW:0] commit_ptr;
  logic [7:0]  len_q;
  logic [7:0]  csum;
  logic [7:0]  cnt;
  logic [8:0]  mem [DEPTH];
  logic [8:0]  head;
  logic        wr_en;
  logic        last_byte;
  logic        timeout;

  function automatic logic [15:0] free_space(input logic [AW:0] wp, input logic [AW:0] rp);
    logic [AW:0] used;
    used = wp - rp;
    return 16'(DEPTH) - 16'(used);
  endfunction

  function automatic logic len_bad(input logic [7:0] len);
    return (len == 8'd0) || (16'(len) > 16'(MAX_LEN));
  endfunction

  assign last_byte = (cnt == len_q - 8'd1);
  assign wr_en     = (state == S_PAYLOAD) && rx_valid;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // tmo_cnt holds the number of idle clocks already elapsed inside a frame
  assign timeout = (state != S_SYNC) && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (rx_valid || (state == S_SYNC) || timeout) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_SYNC;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len_q      <= '0;
      csum       <= '0;
      cnt        <= '0;
      pkt_ok     <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;
      if (timeout) begin
        wr_ptr   <= commit_ptr;
        pkt_err  <= 1'b1;
        err_code <= 2'd0;
        state    <= S_SYNC;
      end else if (rx_valid) begin
        case (state)
          S_SYNC: begin
            if (rx_data == SYNC_BYTE) state <= S_LEN;
          end
          S_LEN: begin
            // Space only grows while the frame arrives, so checking once here is enough
            if (len_bad(rx_data)) begin
              pkt_err  <= 1'b1;
              err_code <= 2'd1;
              state    <= S_SYNC;
            end else if (16'(rx_data) > free_space(wr_ptr, rd_ptr)) begin
              pkt_err  <= 1'b1;
              err_code <= 2'd2;
              state    <= S_SYNC;
            end else begin
              len_q <= rx_data;
              csum  <= rx_data;
              cnt   <= 8'd0;
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            wr_ptr <= wr_ptr + 1'b1;
            csum   <= csum ^ rx_data;
            cnt    <= cnt + 8'd1;
            if (last_byte) state <= S_CHECK;
          end
          S_CHECK: begin
            if (rx_data == csum) begin
              commit_ptr <= wr_ptr;
              pkt_ok     <= 1'b1;
            end else begin
              wr_ptr   <= commit_ptr;
              pkt_err  <= 1'b1;
              err_code <= 2'd3;
            end
            state <= S_SYNC;
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {last_byte, rx_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
    end else if (out_valid && out_ready) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Reads stop at commit_ptr, so bytes of a frame still being checked stay hidden
  assign out_valid = (rd_ptr != commit_ptr);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_data  = out_valid ? head[7:0] : 8'd0;
  assign out_last  = out_valid & head[8];

endmodule
